// File: rtl/commit_trace_buffer_pkg.sv
// Shared record layout for the commit trace buffer: field widths, bit offsets
// inside a packed record, and the saturating drop-counter helper.
package commit_trace_buffer_pkg;

  localparam int TR_PC_W  = 32;
  localparam int TR_REG_W = 5;
  localparam int TR_VAL_W = 32;
  localparam int DROP_W   = 16;

  // Record is packed LSB-first as {seq, pc, ena, reg, value}
  localparam int TR_VAL_LSB = 0;
  localparam int TR_REG_LSB = TR_VAL_LSB + TR_VAL_W;
  localparam int TR_ENA_LSB = TR_REG_LSB + TR_REG_W;
  localparam int TR_PC_LSB  = TR_ENA_LSB + 1;
  localparam int TR_SEQ_LSB = TR_PC_LSB + TR_PC_W;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/commit_trace_buffer_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers; a push
// while full is accepted only when a pop frees the head slot on the same edge.
module trace_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Storage is reset as well so the head reads as zero out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Buffers one record per retired instruction from the WB debug outputs and
// drains them over valid/ready; drops are visible via seq gaps, flag and count.
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                wb_have_inst,
  input  logic [TR_PC_W-1:0]  wb_pc,
  input  logic                wb_ena,
  input  logic [TR_REG_W-1:0] wb_reg,
  input  logic [TR_VAL_W-1:0] wb_value,
  output logic                trace_valid,
  input  logic                trace_ready,
  output logic [SEQ_W-1:0]    trace_seq,
  output logic [TR_PC_W-1:0]  trace_pc,
  output logic                trace_ena,
  output logic [TR_REG_W-1:0] trace_reg,
  output logic [TR_VAL_W-1:0] trace_value,
  output logic                full,
  output logic                overflow,
  output logic [DROP_W-1:0]   drop_cnt
);
  localparam int REC_W = TR_SEQ_LSB + SEQ_W;

  logic [SEQ_W-1:0] seq;
  logic             eff_ena;
  logic             push_try;
  logic             drop;
  logic             fifo_empty;
  logic [REC_W-1:0] wdata;
  logic [REC_W-1:0] rdata;

  assign eff_ena  = wb_ena && (wb_reg != '0);
  assign push_try = wb_have_inst && !clr;
  // When full the head is valid, so a pop happens exactly when ready is high
  assign drop     = push_try && full && !trace_ready;

  assign wdata = {seq, wb_pc, eff_ena,
                  eff_ena ? wb_reg : {TR_REG_W{1'b0}},
                  eff_ena ? wb_value : {TR_VAL_W{1'b0}}};

  trace_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push_try),
    .wdata (wdata),
    .pop   (trace_ready),
    .rdata (rdata),
    .full  (full),
    .empty (fifo_empty)
  );

  assign trace_valid = !fifo_empty;
  assign trace_seq   = rdata[TR_SEQ_LSB +: SEQ_W];
  assign trace_pc    = rdata[TR_PC_LSB  +: TR_PC_W];
  assign trace_ena   = rdata[TR_ENA_LSB];
  assign trace_reg   = rdata[TR_REG_LSB +: TR_REG_W];
  assign trace_value = rdata[TR_VAL_LSB +: TR_VAL_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push_try) seq <= seq + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: stimulus queues expected records,
// a negedge monitor compares every handshake and checks stall stability.
module tb_commit_trace_buffer;
  localparam int DEPTH = 16;
  localparam int SEQ_W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        wb_have_inst = 1'b0;
  logic [31:0] wb_pc = '0;
  logic        wb_ena = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_value = '0;
  logic        trace_valid;
  logic        trace_ready = 1'b1;
  logic [15:0] trace_seq;
  logic [31:0] trace_pc;
  logic        trace_ena;
  logic [4:0]  trace_reg;
  logic [31:0] trace_value;
  logic        full;
  logic        overflow;
  logic [15:0] drop_cnt;

  typedef struct {
    logic [15:0] seq;
    logic [31:0] pc;
    logic        ena;
    logic [4:0]  rg;
    logic [31:0] val;
  } rec_t;

  rec_t        q[$];
  logic [15:0] exp_seq = '0;
  int          cmp_cnt = 0;
  int          err_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [85:0] prev_data = '0;
  logic        rst_seen = 1'b0;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wb_have_inst(wb_have_inst), .wb_pc(wb_pc), .wb_ena(wb_ena),
    .wb_reg(wb_reg), .wb_value(wb_value),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_seq(trace_seq), .trace_pc(trace_pc), .trace_ena(trace_ena),
    .trace_reg(trace_reg), .trace_value(trace_value),
    .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    wb_have_inst = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [31:0] pc, input logic ena, input logic [4:0] rg,
                      input logic [31:0] val, input logic e_ena, input logic [4:0] e_rg,
                      input logic [31:0] e_val, input bit store);
    rec_t r;
    wb_have_inst = 1'b1;
    wb_pc = pc; wb_ena = ena; wb_reg = rg; wb_value = val;
    r.seq = exp_seq; r.pc = pc; r.ena = e_ena; r.rg = e_rg; r.val = e_val;
    if (store) q.push_back(r);
    exp_seq++;
    tick();
  endtask

  always @(posedge rst) rst_seen = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !rst_seen)
        check("stall_hold", {trace_valid, trace_seq, trace_pc, trace_ena, trace_reg, trace_value},
              {1'b1, prev_data});
      if (trace_valid && trace_ready && !clr) begin
        if (q.size() == 0) begin
          check("sb_underflow", {112'd0, trace_seq}, 128'h1_0000);
        end else begin
          rec_t e;
          e = q.pop_front();
          check("sb_record", {trace_seq, trace_pc, trace_ena, trace_reg, trace_value},
                {e.seq, e.pc, e.ena, e.rg, e.val});
        end
      end
      prev_stall = trace_valid && !trace_ready && !clr;
      prev_data  = {trace_seq, trace_pc, trace_ena, trace_reg, trace_value};
    end
    rst_seen = 1'b0;
  end

  initial begin
    logic [31:0] rmask;
    rmask = 32'hB6D3_AD6B;

    // Reset state
    #12;
    check("rst_flags", {trace_valid, full, overflow, drop_cnt}, 19'd0);
    check("rst_data", {trace_seq, trace_pc, trace_ena, trace_reg, trace_value}, 86'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic capture with one-cycle visibility
    trace_ready = 1'b1;
    check("empty_before", {127'd0, trace_valid}, 128'd0);
    push(32'h0, 1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h11, 1'b1);
    check("lat0", {trace_valid, trace_seq}, {1'b1, 16'd0});
    push(32'h4, 1'b1, 5'd6, 32'h22, 1'b1, 5'd6, 32'h22, 1'b1);
    check("lat1", {trace_valid, trace_seq, trace_pc}, {1'b1, 16'd1, 32'h4});
    push(32'h8, 1'b1, 5'd7, 32'h33, 1'b1, 5'd7, 32'h33, 1'b1);
    check("lat2", {trace_valid, trace_seq, trace_reg, trace_value}, {1'b1, 16'd2, 5'd7, 32'h33});
    idle(1);
    check("drained", {127'd0, trace_valid}, 128'd0);

    // x0 write and non-writing instruction
    push(32'h10, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0, 1'b1);
    check("x0_fields", {trace_ena, trace_reg, trace_value}, 38'd0);
    push(32'h14, 1'b0, 5'd9, 32'hBEEF, 1'b0, 5'd0, 32'h0, 1'b1);
    check("noena_fields", {trace_ena, trace_reg, trace_value}, 38'd0);
    idle(2);

    // clr together with a push: push lost, seq restarts
    wb_have_inst = 1'b1; wb_pc = 32'h99; clr = 1'b1;
    q.delete(); exp_seq = '0;
    tick();
    clr = 1'b0;
    idle(1);
    check("clr_empty", {trace_valid, full, overflow, drop_cnt}, 19'd0);

    // Overflow: DEPTH+3 pushes with consumer stalled
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++)
      push(32'(32'h200 + 4 * i), 1'b1, 5'd1, 32'(i), 1'b1, 5'd1, 32'(i), i < DEPTH);
    check("ovf_flags", {full, overflow, drop_cnt}, {1'b1, 1'b1, 16'd3});
    check("ovf_head", {112'd0, trace_seq}, 128'd0);

    // Full boundary: simultaneous push and pop, next seq is DEPTH+3
    trace_ready = 1'b1;
    push(32'h300, 1'b1, 5'd2, 32'h77, 1'b1, 5'd2, 32'h77, 1'b1);
    check("full_pushpop", {full, overflow, drop_cnt}, {1'b1, 1'b1, 16'd3});
    idle(DEPTH + 4);
    check("after_drain", {trace_valid, full, overflow, drop_cnt}, {1'b0, 1'b0, 1'b1, 16'd3});

    // Stall stability with irregular ready and retirement gaps
    for (int i = 0; i < 40; i++) begin
      trace_ready = rmask[i % 32];
      if (i % 3 != 2)
        push(32'(32'h400 + 4 * i), 1'b1, 5'(i), 32'(i * 32'h01010101), (i % 32) != 0,
             ((i % 32) != 0) ? 5'(i) : 5'd0, ((i % 32) != 0) ? 32'(i * 32'h01010101) : 32'd0, 1'b1);
      else
        idle(1);
    end
    trace_ready = 1'b1;
    idle(DEPTH + 4);
    check("stall_drained", {126'd0, trace_valid, full}, 128'd0);

    // clr with records buffered and sticky overflow set
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(32'(32'h500 + 4 * i), 1'b1, 5'd3, 32'(i), 1'b1, 5'd3, 32'(i), 1'b1);
    wb_have_inst = 1'b1; clr = 1'b1;
    q.delete(); exp_seq = '0;
    tick();
    clr = 1'b0;
    idle(1);
    check("clr_flush", {trace_valid, full, overflow, drop_cnt}, 19'd0);
    trace_ready = 1'b1;
    push(32'h600, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 32'h44, 1'b1);
    check("clr_seq0", {trace_valid, trace_seq}, {1'b1, 16'd0});
    idle(2);

    // Async reset in the middle of a burst with drops pending
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++)
      push(32'(32'h700 + 4 * i), 1'b1, 5'd8, 32'(i), 1'b1, 5'd8, 32'(i), i < DEPTH);
    check("pre_rst", {full, overflow, drop_cnt}, {1'b1, 1'b1, 16'd2});
    #2 rst = 1'b1;
    #1;
    check("async_rst_flags", {trace_valid, full, overflow, drop_cnt}, 19'd0);
    check("async_rst_data", {trace_seq, trace_pc, trace_ena, trace_reg, trace_value}, 86'd0);
    q.delete(); exp_seq = '0;
    @(posedge clk); #1 rst = 1'b0;
    trace_ready = 1'b1;
    push(32'h800, 1'b1, 5'd10, 32'hAA, 1'b1, 5'd10, 32'hAA, 1'b1);
    check("rst_seq0", {trace_valid, trace_seq}, {1'b1, 16'd0});
    idle(3);

    check("sb_empty", 128'(q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
